srl_word_loader: RTL and testbench
==================================

Name: srl_word_loader

Overview:
- Upstream feeder for the SRL shift-register primitive (clk / wr_en / i_data / addr / o_data).
- Accepts parallel words over a valid/ready handshake and serializes them one bit per cycle into the SRL chain.
- Tracks how many bits the chain holds, so it drives the SRL tap address that selects the oldest valid bit.
- Sits between the weight/activation fetch logic and the SRL delay lines in the BNA datapath.

Parameters:
- DATA_WIDTH, 8: bits per input word; must be ≥2.
- ADDR_WIDTH, 5: SRL address width; chain depth is DEPTH = 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  loader can accept a word this cycle.
- i_data  input  DATA_WIDTH  upstream word.
- i_stall  input  1  downstream hold; suppresses shifting.
- i_clear  input  1  synchronous clear of the fill count.
- o_srl_wr_en  output  1  to SRL wr_en.
- o_srl_data  output  1  to SRL i_data.
- o_srl_addr  output  ADDR_WIDTH  to SRL addr; tap of the oldest valid bit.
- o_fill  output  ADDR_WIDTH+1  valid bits in the chain, 0..DEPTH.
- o_busy  output  1  serialization in progress.
- o_word_done  output  1  one-cycle pulse after the last bit of a word is shifted.

Behaviour:
- Reset (asynchronous) sets all registers and outputs to 0:
  - state=IDLE, shift register=0, bit_cnt=0, fill=0.
  - o_word_done=0, o_srl_wr_en=0, o_srl_addr=0, o_busy=0.
  - o_ready=0 while rst is asserted; o_ready=1 in the first cycle after release.
- State machine, two states:
  - IDLE: o_ready=!i_stall. On i_valid&&o_ready: latch i_data into sreg, clear bit_cnt, go to SHIFT.
  - SHIFT: o_busy=1. In each cycle with i_stall=0:
    - o_srl_wr_en=1.
    - o_srl_data=sreg[DATA_WIDTH-1] (MSB first).
    - sreg shifts left one bit; bit_cnt increments.
- o_srl_wr_en and o_srl_data are combinational from state, sreg and i_stall. The SRL registers them, so a bit is visible in the SRL one cycle after its strobe.
- Last bit (bit_cnt==DATA_WIDTH-1, not stalled):
  - o_ready=1 in that cycle.
  - If i_valid: load the new word and stay in SHIFT, giving back-to-back streaming with no bubble cycle.
  - Otherwise: return to IDLE.
  - In both cases o_word_done pulses in the following cycle.
- Stall: i_stall=1 freezes sreg, bit_cnt, state and fill, and forces o_ready=0. It does not clear o_word_done if that pulse is already registered.
- Fill counter:
  - Increments on every o_srl_wr_en.
  - Saturates at DEPTH; the SRL still shifts and the oldest bit is lost.
  - o_srl_addr = (fill==0) ? 0 : fill-1, truncated to ADDR_WIDTH.
- i_clear sets fill to 0 on the next edge without affecting the FSM. If i_clear and o_srl_wr_en occur in the same cycle, fill=1.
- Throughput: one word per DATA_WIDTH cycles; latency from handshake to first strobe is 1 cycle.
- A reset mid-word discards the partial word. The SRL contents are not cleared; only fill returns to 0.

Optional Feature:
- Macro: SRL_WORD_LOADER_LSB_FIRST_EN.
- Defined: each word is serialized LSB first. o_srl_data=sreg[0] and sreg shifts right.
- Undefined: MSB first, as described under Behaviour.
- Handshake, timing and fill are identical in both builds.

Decomposition:
- Shared package bna_srl_pkg holds:
  - state enum {ST_IDLE, ST_SHIFT};
  - default width constants;
  - a helper function for the fill-to-address mapping.
- No sub-module is needed in the loader itself. srl_word_loader instantiates alongside SRLC_RTL in a wrapper srl_loader_top for test.

Test Plan:
- Reset, then one word 8'hA5 with i_valid=1 for one cycle:
  - o_srl_data sequence over 8 strobes is 1,0,1,0,0,1,0,1;
  - o_word_done pulses at cycle 9;
  - o_fill=8, o_srl_addr=7;
  - the SRL o_data equals 1 (the oldest bit).
- Two words 8'hFF and 8'h00 with i_valid held high:
  - 16 consecutive strobes with no gap;
  - o_ready is high only on cycles 8 and 16;
  - two o_word_done pulses, 8 cycles apart.
- Stall of 3 cycles inserted after bit 4 of 8'h3C:
  - o_srl_wr_en is low for exactly those 3 cycles;
  - the bit sequence is unchanged;
  - o_word_done is delayed by 3 cycles.
- Five words loaded (40 bits) with DEPTH=32:
  - o_fill saturates at 32 and o_srl_addr=31;
  - i_clear then gives fill 0; the next word gives fill 8.
- rst asserted after bit 3 of a word:
  - outputs go to 0 immediately (asynchronously);
  - after release, a new word 8'h81 serializes correctly starting at bit 0.
- LSB_FIRST build with 8'h01: first strobe carries 1, followed by seven 0s.

Source files
------------

// File: rtl/bna_srl_pkg.sv
// Shared definitions for the BNA SRL feeder: loader states, default widths,
// and the mapping from fill count to the SRL tap address.
package bna_srl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // The oldest valid bit sits at tap fill-1; an empty chain points at tap 0.
  function automatic int fill_to_addr(input int fill);
    return (fill == 0) ? 0 : fill - 1;
  endfunction

endpackage

// File: rtl/srl_word_loader.sv
// Serializes parallel words into an SRL chain one bit per cycle and tracks the
// chain fill level. Bit order is MSB first; define SRL_WORD_LOADER_LSB_FIRST_EN for LSB first.
module srl_word_loader
  import bna_srl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_stall,
  input  logic                  i_clear,
  output logic                  o_srl_wr_en,
  output logic                  o_srl_data,
  output logic [ADDR_WIDTH-1:0] o_srl_addr,
  output logic [ADDR_WIDTH:0]   o_fill,
  output logic                  o_busy,
  output logic                  o_word_done
);

  localparam int CNT_W  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam int FILL_W = ADDR_WIDTH + 1;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  done_q, done_d;

  logic ready_c;
  logic wr_en_c;
  logic data_c;
  logic last_c;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    ready_c   = 1'b0;
    wr_en_c   = 1'b0;
    data_c    = 1'b0;
    last_c    = 1'b0;
    o_busy    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_c = !i_stall;
        if (i_valid && ready_c) begin
          sreg_d    = i_data;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        o_busy = 1'b1;
        if (!i_stall) begin
          wr_en_c   = 1'b1;
`ifdef SRL_WORD_LOADER_LSB_FIRST_EN
          data_c    = sreg_q[0];
          sreg_d    = {1'b0, sreg_q[DATA_WIDTH-1:1]};
`else
          data_c    = sreg_q[DATA_WIDTH-1];
          sreg_d    = {sreg_q[DATA_WIDTH-2:0], 1'b0};
`endif
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_LAST) begin
            // Accepting on the last bit keeps a continuous stream bubble-free.
            last_c  = 1'b1;
            ready_c = 1'b1;
            if (i_valid) begin
              sreg_d    = i_data;
              bit_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fill_d = fill_q;
    if (i_clear) begin
      fill_d = wr_en_c ? FILL_W'(1) : '0;
    end else if (wr_en_c && (fill_q != FILL_FULL)) begin
      fill_d = fill_q + FILL_W'(1);
    end
    done_d = last_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      fill_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      fill_q    <= fill_d;
      done_q    <= done_d;
    end
  end

  // Ready is held low for as long as reset is applied, not just until the next edge.
  assign o_ready     = ready_c && !rst;
  assign o_srl_wr_en = wr_en_c;
  assign o_srl_data  = data_c;
  assign o_fill      = fill_q;
  assign o_srl_addr  = ADDR_WIDTH'(fill_to_addr(int'(fill_q)));
  assign o_word_done = done_q;

endmodule

// File: tb/tb_srl_word_loader.sv
// Self-checking bench for srl_word_loader: queue-based bit-stream model,
// a shadow SRL chain, directed scenarios and a randomized run.
module tb_srl_word_loader;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data = '0;
  logic          i_stall = 1'b0;
  logic          i_clear = 1'b0;
  logic          o_srl_wr_en;
  logic          o_srl_data;
  logic [AW-1:0] o_srl_addr;
  logic [AW:0]   o_fill;
  logic          o_busy;
  logic          o_word_done;

  srl_word_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .i_stall    (i_stall),
    .i_clear    (i_clear),
    .o_srl_wr_en(o_srl_wr_en),
    .o_srl_data (o_srl_data),
    .o_srl_addr (o_srl_addr),
    .o_fill     (o_fill),
    .o_busy     (o_busy),
    .o_word_done(o_word_done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Model: bits still to be sent, bits already sent (newest first), fill level, pending done pulse.
  bit mq[$];
  bit hist[$];
  int fill_m = 0;
  bit done_m = 1'b0;

  logic [DEPTH-1:0] srl_tb = '0;

  logic s_wr, s_data, s_rdy, s_done;
  int   s_fill, s_addr;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    for (int i = 0; i < DW; i++) begin
`ifdef SRL_WORD_LOADER_LSB_FIRST_EN
      mq.push_back(d[i]);
`else
      mq.push_back(d[DW-1-i]);
`endif
    end
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit st, input bit cl);
    int n;
    bit e_busy, e_wr, e_rdy, e_data, hs;
    @(negedge clk);
    i_valid = v; i_data = d; i_stall = st; i_clear = cl;
    #1;
    n      = mq.size();
    e_busy = (n > 0);
    e_wr   = e_busy && !st;
    e_data = e_busy ? mq[0] : 1'b0;
    e_rdy  = !st && (n <= 1);
    hs     = v && e_rdy;
    chk("ready", int'(o_ready), int'(e_rdy));
    chk("busy", int'(o_busy), int'(e_busy));
    chk("wr_en", int'(o_srl_wr_en), int'(e_wr));
    chk("word_done", int'(o_word_done), int'(done_m));
    chk("fill", int'(o_fill), fill_m);
    chk("addr", int'(o_srl_addr), (fill_m == 0) ? 0 : fill_m - 1);
    if (e_wr) chk("srl_data", int'(o_srl_data), int'(e_data));
    if (fill_m > 0) chk("srl_tap", int'(srl_tb[fill_m-1]), int'(hist[fill_m-1]));
    s_wr = o_srl_wr_en; s_data = o_srl_data; s_rdy = o_ready; s_done = o_word_done;
    s_fill = int'(o_fill); s_addr = int'(o_srl_addr);
    @(posedge clk);
    if (s_wr) srl_tb = {srl_tb[DEPTH-2:0], s_data};
    done_m = e_wr && (n == 1);
    if (e_wr) begin
      hist.push_front(mq.pop_front());
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
    if (hs) push_word(d);
    if (cl) fill_m = e_wr ? 1 : 0;
    else if (e_wr && fill_m < DEPTH) fill_m++;
  endtask

  task automatic model_reset();
    mq.delete();
    fill_m = 0;
    done_m = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0]   seq;
    logic [2*DW-1:0] seq16;
    int nstb, done_at, done2_at, rdy_cnt, gap, exp_first;

    #3;
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_wr_en", int'(o_srl_wr_en), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_fill", int'(o_fill), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single word A5
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_ready_after_rst", int'(s_rdy), 1);
    seq = '0; nstb = 0; done_at = -1;
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      if (s_wr) begin seq = {seq[DW-2:0], s_data}; nstb++; end
      if (s_done) done_at = k;
    end
    chk("a5_seq", int'(seq), 8'hA5);
    chk("a5_strobes", nstb, 8);
    chk("a5_done_cycle", done_at, 9);
    chk("a5_fill", s_fill, 8);
    chk("a5_addr", s_addr, 7);
    chk("a5_model_fill", fill_m, 8);
    chk("a5_oldest_bit", int'(srl_tb[7]), 1);

    // Back-to-back FF, 00
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    seq16 = '0; nstb = 0; rdy_cnt = 0; done_at = -1; done2_at = -1; gap = 0;
    for (int k = 1; k <= 18; k++) begin
      cycle(k <= 8, 8'h00, 1'b0, 1'b0);
      if (k <= 16) begin
        if (s_wr) begin seq16 = {seq16[2*DW-2:0], s_data}; nstb++; end
        else gap++;
        if (s_rdy) rdy_cnt++;
        if (k == 8 || k == 16) chk("ff00_ready_at_last", int'(s_rdy), 1);
      end
      if (s_done) begin
        if (done_at < 0) done_at = k; else done2_at = k;
      end
    end
    chk("ff00_seq", int'(seq16), 16'hFF00);
    chk("ff00_strobes", nstb, 16);
    chk("ff00_gaps", gap, 0);
    chk("ff00_ready_count", rdy_cnt, 2);
    chk("ff00_done1", done_at, 9);
    chk("ff00_done2", done2_at, 17);

    // 3C with a 3-cycle stall after bit 4
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    seq = '0; nstb = 0; gap = 0; done_at = -1;
    for (int k = 1; k <= 13; k++) begin
      cycle(1'b0, 8'h00, (k >= 5 && k <= 7), 1'b0);
      if (s_wr) begin seq = {seq[DW-2:0], s_data}; nstb++; end
      else if (k <= 11) gap++;
      if (s_done) done_at = k;
    end
    chk("stall_seq", int'(seq), 8'h3C);
    chk("stall_strobes", nstb, 8);
    chk("stall_gap", gap, 3);
    chk("stall_done_cycle", done_at, 12);

    // Five streamed words saturate a 32-deep chain
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int k = 1; k <= 41; k++)
      cycle((k <= 32) && (k % 8 == 0), DW'($urandom), 1'b0, 1'b0);
    chk("sat_fill", s_fill, 32);
    chk("sat_addr", s_addr, 31);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clear_fill", s_fill, 0);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("refill_fill", s_fill, 8);

    // Asynchronous reset after bit 3
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_wr_en", int'(o_srl_wr_en), 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_ready", int'(o_ready), 0);
    chk("arst_fill", int'(o_fill), 0);
    chk("arst_addr", int'(o_srl_addr), 0);
    chk("arst_done", int'(o_word_done), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 8'h81, 1'b0, 1'b0);
    seq = '0; nstb = 0; done_at = -1;
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      if (s_wr) begin seq = {seq[DW-2:0], s_data}; nstb++; end
      if (s_done) done_at = k;
    end
    chk("post_rst_seq", int'(seq), 8'h81);
    chk("post_rst_done", done_at, 9);

    // Word 01: bit order distinguishes the two builds
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    seq = '0; exp_first = -1;
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      if (s_wr) begin
        if (exp_first < 0) exp_first = int'(s_data);
        seq = {seq[DW-2:0], s_data};
      end
    end
`ifdef SRL_WORD_LOADER_LSB_FIRST_EN
    chk("w01_first_bit", exp_first, 1);
    chk("w01_seq", int'(seq), 8'h80);
`else
    chk("w01_first_bit", exp_first, 0);
    chk("w01_seq", int'(seq), 8'h01);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++)
      cycle($urandom_range(0, 9) < 6, DW'($urandom),
            $urandom_range(0, 9) < 2, $urandom_range(0, 99) < 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
